// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//
// UART receiver with oversampling and runtime-selectable frame format.
// Every frame starts with a start bit. It carries 7 or 8 data bits, sent LSB
// first. An odd or even parity bit is optional. The frame ends with one or
// two stop bits. The format and the baud rate are captured at the start edge
// and stay fixed for the rest of the frame.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   OVS         oversample ticks per bit period
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   in_data     serial line, idle high
//   bd_rate     baud select: 0=1200, 1=2400, 2=4800, 3=9600
//   para        parity: 0=none, 1=odd, 2=even, 3=none
//   s_num       stop bits: 0=one, 1=two
//   d_num       data bits: 0=seven, 1=eight
//   out_data    last received word (bit7 = 0 in 7-bit mode)
//   data_valid  one-clock pulse when a frame completes
//   parity_err  parity mismatch on the last completed frame
//   frame_err   a stop bit sampled low on the last completed frame
//   busy        high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int CLK_FREQ = 50000000,
    parameter int OVS      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_data,
    input  logic [1:0] bd_rate,
    input  logic [1:0] para,
    input  logic       s_num,
    input  logic       d_num,
    output logic [7:0] out_data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV_1200 = CLK_FREQ / (OVS * 1200);
    localparam int DIV_2400 = CLK_FREQ / (OVS * 2400);
    localparam int DIV_4800 = CLK_FREQ / (OVS * 4800);
    localparam int DIV_9600 = CLK_FREQ / (OVS * 9600);

    // The 1200 baud divisor is the largest, so it sets the counter width.
    localparam int CW = (DIV_1200 > 1) ? $clog2(DIV_1200) : 1;
    localparam int SW = (OVS > 1) ? $clog2(OVS) : 1;

    localparam logic [SW-1:0] SUB_HALF = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] SUB_FULL = SW'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t state;
    state_t state_next;

    logic          sync_1;
    logic          sync_2;
    logic          rx_prev;

    logic [CW-1:0] tick_cnt;
    logic [SW-1:0] sub_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          stop_err;

    logic [1:0]    cfg_baud;
    logic [1:0]    cfg_par;
    logic          cfg_stop2;
    logic          cfg_d8;

    logic [CW-1:0] div_m1;
    logic          start_edge;
    logic          tick;
    logic          sample;
    logic          last_bit;
    logic          par_en;
    logic          frame_done;
    logic [7:0]    data_word;
    logic          par_calc;

    // Two-flop synchronizer. A third flop keeps the previous synchronized
    // value for edge detection. All three reset to the idle-high level, so a
    // line that sits high produces no edge when reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1  <= 1'b1;
            sync_2  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_1  <= in_data;
            sync_2  <= sync_1;
            rx_prev <= sync_2;
        end
    end

    // Combinational helpers. The tick divisor comes from the latched baud
    // select. The sample strobe fires at mid start bit and then once every
    // OVS ticks. A frame completes at the sample of its last stop bit.
    always_comb begin
        div_m1     = CW'(DIV_1200 - 1);
        start_edge = 1'b0;
        tick       = 1'b0;
        sample     = 1'b0;
        last_bit   = 1'b0;
        par_en     = 1'b0;
        frame_done = 1'b0;
        data_word  = 8'h00;
        par_calc   = 1'b0;

        case (cfg_baud)
            2'd0:    div_m1 = CW'(DIV_1200 - 1);
            2'd1:    div_m1 = CW'(DIV_2400 - 1);
            2'd2:    div_m1 = CW'(DIV_4800 - 1);
            default: div_m1 = CW'(DIV_9600 - 1);
        endcase

        start_edge = (state == IDLE) && rx_prev && !sync_2;
        tick       = (state != IDLE) && (tick_cnt == div_m1);
        sample     = tick && (sub_cnt == ((state == START) ? SUB_HALF : SUB_FULL));
        last_bit   = (bit_cnt == (cfg_d8 ? 3'd7 : 3'd6));
        par_en     = (cfg_par == 2'b01) || (cfg_par == 2'b10);
        frame_done = sample && (((state == STOP1) && !cfg_stop2) || (state == STOP2));
        data_word  = cfg_d8 ? shreg : {1'b0, shreg[7:1]};

        case (cfg_par)
            2'b01:   par_calc = ~(^data_word ^ par_bit);
            2'b10:   par_calc = ^data_word ^ par_bit;
            default: par_calc = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A high sample at mid start bit means the start was
    // false. The receiver then drops back to IDLE without touching any
    // output.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_edge) state_next = START;
            end
            START: begin
                if (sample) state_next = sync_2 ? IDLE : DATA;
            end
            DATA: begin
                if (sample && last_bit) state_next = par_en ? PARITY : STOP1;
            end
            PARITY: begin
                if (sample) state_next = STOP1;
            end
            STOP1: begin
                if (sample) state_next = cfg_stop2 ? STOP2 : IDLE;
            end
            STOP2: begin
                if (sample) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: counters, shift register and frame configuration. The frame
    // configuration is captured on the start edge. The outputs are updated
    // only when a frame completes, and they then hold until the next frame
    // completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt   <= '0;
            sub_cnt    <= '0;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            stop_err   <= 1'b0;
            cfg_baud   <= 2'd0;
            cfg_par    <= 2'd0;
            cfg_stop2  <= 1'b0;
            cfg_d8     <= 1'b0;
            out_data   <= 8'h00;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == IDLE) begin
                tick_cnt <= '0;
                sub_cnt  <= '0;
                if (start_edge) begin
                    bit_cnt   <= 3'd0;
                    par_bit   <= 1'b0;
                    stop_err  <= 1'b0;
                    cfg_baud  <= bd_rate;
                    cfg_par   <= para;
                    cfg_stop2 <= s_num;
                    cfg_d8    <= d_num;
                end
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick) begin
                    sub_cnt <= sample ? '0 : sub_cnt + 1'b1;
                end
                if (sample) begin
                    case (state)
                        DATA: begin
                            shreg   <= {sync_2, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        PARITY: par_bit <= sync_2;
                        STOP1:  if (!sync_2) stop_err <= 1'b1;
                        default: ;
                    endcase
                end
                if (frame_done) begin
                    data_valid <= 1'b1;
                    out_data   <= data_word;
                    parity_err <= par_calc;
                    frame_err  <= stop_err | ~sync_2;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
//
// Scoreboard bench for uart_rx_frame. The clock frequency is scaled down so
// that the baud divisors are 8/4/2/1, which keeps frames short. The frame
// driver builds each bit stream from the frame-format rules. It pushes the
// expected word and flags onto a queue. An independent monitor pops an entry
// whenever data_valid pulses and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

    localparam int CLK_FREQ = 153600;
    localparam int OVS      = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_data = 1'b1;
    logic [1:0] bd_rate = 2'd0;
    logic [1:0] para = 2'd0;
    logic       s_num = 1'b0;
    logic       d_num = 1'b1;
    logic [7:0] out_data;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t sbQ[$];
    exp_t lastExp = '0;

    int   checks = 0;
    int   errors = 0;
    int   validCount = 0;
    int   cycle = 0;
    int   startCycle = 0;
    int   lastValidCycle = 0;
    logic prevValid = 1'b0;

    uart_rx_frame #(
        .CLK_FREQ(CLK_FREQ),
        .OVS(OVS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .bd_rate(bd_rate),
        .para(para),
        .s_num(s_num),
        .d_num(d_num),
        .out_data(out_data),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Clock cycles per bit at the given baud select, from the rate itself.
    function automatic int bitClocks(input int sel);
        int rate;
        rate = 1200 << sel;
        return (CLK_FREQ / (OVS * rate)) * OVS;
    endfunction

    // Monitor: every data_valid pulse must match the oldest pending frame.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (data_valid === 1'b1) begin
                validCount++;
                lastValidCycle = cycle;
                checkOutput("valid_single_pulse", {31'd0, prevValid}, 32'd0);
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_valid: got data_valid with out_data=0x%0h, expected no frame", out_data);
                end else begin
                    lastExp = sbQ.pop_front();
                    checkOutput("out_data", {24'd0, out_data}, {24'd0, lastExp.data});
                    checkOutput("parity_err", {31'd0, parity_err}, {31'd0, lastExp.perr});
                    checkOutput("frame_err", {31'd0, frame_err}, {31'd0, lastExp.ferr});
                end
            end
            prevValid = data_valid;
        end else begin
            prevValid = 1'b0;
        end
    end

    // After the idle gap, the frame must have been consumed, the receiver
    // must be idle, and the outputs must still show that frame.
    task automatic frameDone();
        checkOutput("frame_received", sbQ.size(), 32'd0);
        if (sbQ.size() != 0) sbQ.delete();
        checkOutput("busy_idle", {31'd0, busy}, 32'd0);
        checkOutput("out_data_hold", {24'd0, out_data}, {24'd0, lastExp.data});
        checkOutput("parity_err_hold", {31'd0, parity_err}, {31'd0, lastExp.perr});
        checkOutput("frame_err_hold", {31'd0, frame_err}, {31'd0, lastExp.ferr});
    endtask

    // Drive one frame. A non-negative abortAt pulls reset low just before
    // bit number abortAt would be driven (bit 0 is the start bit).
    task automatic applyStimulus(input logic [7:0] data, input int baud, input bit d8,
                                 input logic [1:0] par, input bit st2, input bit flipPar,
                                 input bit stop1Val, input bit stop2Val, input bit scramble,
                                 input int abortAt, input bit returnIdle);
        int         bc;
        int         vc;
        logic [7:0] word;
        bit         pbit;
        bit         parEn;
        bit         bits[$];
        exp_t       e;

        bc      = bitClocks(baud);
        bd_rate = baud[1:0];
        para    = par;
        s_num   = st2;
        d_num   = d8;
        repeat (4) @(negedge clk);

        word  = d8 ? data : (data & 8'h7F);
        parEn = (par == 2'd1) || (par == 2'd2);
        if (par == 2'd1) pbit = ($countones(word) % 2) == 0;
        else             pbit = ($countones(word) % 2) == 1;
        pbit = pbit ^ flipPar;

        bits.push_back(1'b0);
        for (int k = 0; k < (d8 ? 8 : 7); k++) bits.push_back(word[k]);
        if (parEn) bits.push_back(pbit);
        bits.push_back(stop1Val);
        if (st2) bits.push_back(stop2Val);

        e.data = word;
        e.perr = parEn && flipPar;
        e.ferr = !stop1Val || (st2 && !stop2Val);

        for (int i = 0; i < bits.size(); i++) begin
            if (i == abortAt) begin
                rst = 1'b0;
                #1;
                checkOutput("abort_out_data", {24'd0, out_data}, 32'd0);
                checkOutput("abort_data_valid", {31'd0, data_valid}, 32'd0);
                checkOutput("abort_parity_err", {31'd0, parity_err}, 32'd0);
                checkOutput("abort_frame_err", {31'd0, frame_err}, 32'd0);
                checkOutput("abort_busy", {31'd0, busy}, 32'd0);
                repeat (3) @(negedge clk);
                in_data = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b1;
                vc = validCount;
                repeat (2 * bc) @(negedge clk);
                checkOutput("abort_no_valid", validCount, vc);
                checkOutput("abort_busy_after", {31'd0, busy}, 32'd0);
                return;
            end
            if (i == bits.size() - 1) sbQ.push_back(e);
            in_data = bits[i];
            if (i == 0) startCycle = cycle;
            repeat (bc) @(negedge clk);
            if (i == 0) checkOutput("busy_in_frame", {31'd0, busy}, 32'd1);
            if (scramble && i == 1) begin
                bd_rate = 2'($urandom_range(0, 3));
                para    = 2'($urandom_range(0, 3));
                s_num   = 1'($urandom_range(0, 1));
                d_num   = 1'($urandom_range(0, 1));
            end
        end

        if (returnIdle) begin
            in_data = 1'b1;
            repeat (2 * bc) @(negedge clk);
            frameDone();
        end
    endtask

    initial begin
        int vc;
        int bc;
        int lat;

        // Reset values while reset is held.
        rst     = 1'b0;
        in_data = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_out_data", {24'd0, out_data}, 32'd0);
        checkOutput("reset_data_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("reset_parity_err", {31'd0, parity_err}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1200 baud, 7 data bits, no parity, one stop bit, word 0x2D.
        // Expected latency from the start edge is about 8.5 bit times.
        applyStimulus(8'h2D, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b1);
        bc  = bitClocks(0);
        lat = lastValidCycle - startCycle;
        checkOutput("latency_window", {31'd0, (lat > 8 * bc) && (lat < 9 * bc)}, 32'd1);

        // 2400 baud, 8 data bits, odd parity (correct bit is 1), two stop bits.
        applyStimulus(8'h2D, 1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b1);

        // 4800 baud, even parity, parity bit wrongly driven 1.
        applyStimulus(8'h2D, 2, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b1);

        // 9600 baud, two stop bits, second stop low, and the line then stays low.
        applyStimulus(8'h5A, 3, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        vc = validCount;
        bc = bitClocks(3);
        repeat (20 * bc) @(negedge clk);
        checkOutput("low_line_no_retrigger", validCount, vc);
        checkOutput("low_line_busy", {31'd0, busy}, 32'd0);
        checkOutput("low_line_frame_err", {31'd0, frame_err}, 32'd1);
        in_data = 1'b1;
        repeat (2 * bc) @(negedge clk);
        frameDone();
        applyStimulus(8'hC3, 3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b1);

        // 4-tick low glitch at 1200 baud is a false start.
        bd_rate = 2'd0;
        para    = 2'd0;
        s_num   = 1'b0;
        d_num   = 1'b1;
        repeat (4) @(negedge clk);
        bc = bitClocks(0);
        vc = validCount;
        in_data = 1'b0;
        repeat (4 * (bc / OVS)) @(negedge clk);
        in_data = 1'b1;
        repeat (2 * bc) @(negedge clk);
        checkOutput("glitch_no_valid", validCount, vc);
        checkOutput("glitch_busy", {31'd0, busy}, 32'd0);
        applyStimulus(8'hA5, 0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b1);

        // Reset during DATA of a 0x2D frame, then a fresh 0x3C frame.
        applyStimulus(8'h2D, 3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, 1'b1);
        applyStimulus(8'h3C, 3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b1);

        // Randomized frames with mid-frame configuration changes.
        repeat (14) begin
            applyStimulus(8'($urandom_range(0, 255)), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                          1'b1, -1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
